// File: rtl/seven_seg_pkg.sv
// Shared constants for the 8-digit multiplexed seven-segment driver.
// Segment patterns are {A,B,C,D,E,F,G}, active-low (0 = lit).
package seven_seg_pkg;

  localparam int NUM_DIGITS = 8;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [NUM_DIGITS-1:0] ANODES_OFF = 8'hFF;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low {A..G} segment pattern decoder.
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    // NOTE: a default ahead of the case keeps every path assigned, so no latch is inferred.
    seg = SEG_BLANK;
    case (hex)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg.sv
// Demo driver: a slow 32-bit up-counter shown as 8 hex digits on a
// common-anode, time-multiplexed seven-segment display.
module seven_seg
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_CYCLES = 100000,
  parameter int TICK_CYCLES    = 100000000
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       E,
  output logic       F,
  output logic       G,
  output logic [7:0] Anode_Activate
);

  localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [RW-1:0] REF_LAST  = RW'(REFRESH_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  logic [RW-1:0] ref_cnt_q, ref_cnt_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   value_q, value_d;
  logic [7:0]    anode_q, anode_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    nibble;
  logic [6:0]    seg_dec;

  hex_to_seg u_hex_to_seg (
    .hex (nibble),
    .seg (seg_dec)
  );

  // Outputs are decoded from the current index/value; a wrap this cycle
  // is therefore seen by the output registers on the following edge.
  always_comb begin
    ref_cnt_d  = ref_cnt_q + 1'b1;
    tick_cnt_d = tick_cnt_q + 1'b1;
    idx_d      = idx_q;
    value_d    = value_q;
    if (ref_cnt_q == REF_LAST) begin
      ref_cnt_d = '0;
      idx_d     = idx_q + 3'd1;
    end
    if (tick_cnt_q == TICK_LAST) begin
      tick_cnt_d = '0;
      value_d    = value_q + 32'd1;
    end
    nibble  = value_q[{idx_q, 2'b00} +: 4];
    anode_d = ~(8'b1 << idx_q);
    seg_d   = seg_dec;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      ref_cnt_q  <= '0;
      tick_cnt_q <= '0;
      idx_q      <= '0;
      value_q    <= '0;
      anode_q    <= ANODES_OFF;
      seg_q      <= SEG_BLANK;
    end else begin
      ref_cnt_q  <= ref_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      idx_q      <= idx_d;
      value_q    <= value_d;
      anode_q    <= anode_d;
      seg_q      <= seg_d;
    end
  end

  assign {A, B, C, D, E, F, G} = seg_q;
  assign Anode_Activate         = anode_q;

endmodule

// File: tb/tb_seven_seg.sv
// Self-checking bench for seven_seg: directed scenarios plus random run
// lengths, resets and value deposits, checked every cycle against a model.
module tb_seven_seg;

  localparam int REF  = 4;
  localparam int TICK = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       A, B, C, D, E, F, G;
  logic [7:0] an;
  logic [6:0] seg;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Model state: k = clock edges with rst_n high since the last reset edge;
  // the displayed value was base at edge base_k and gains one per TICK edges.
  int unsigned k = 0;
  logic [31:0] base = '0;
  int unsigned base_k = 0;
  logic [6:0]  seg_tbl [16];

  seven_seg #(
    .REFRESH_CYCLES (REF),
    .TICK_CYCLES    (TICK)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .A              (A),
    .B              (B),
    .C              (C),
    .D              (D),
    .E              (E),
    .F              (F),
    .G              (G),
    .Anode_Activate (an)
  );

  assign seg = {A, B, C, D, E, F, G};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: update the model at the edge, compare outputs at the negedge.
  task automatic step();
    int unsigned j, idx;
    logic [31:0] val;
    logic [3:0]  nib;
    logic [7:0]  exp_an;
    @(posedge clk);
    if (!rst_n) begin
      k = 0; base = '0; base_k = 0;
    end else begin
      k++;
    end
    @(negedge clk);
    if (k == 0) begin
      check("rst_anode", {24'd0, an}, 32'hFF);
      check("rst_seg", {25'd0, seg}, 32'h7F);
    end else begin
      j      = k - 1;
      idx    = (j / REF) % 8;
      val    = base + 32'(j / TICK - base_k / TICK);
      nib    = val[4*idx +: 4];
      exp_an = ~(8'b1 << idx);
      check("anode", {24'd0, an}, {24'd0, exp_an});
      check("seg", {25'd0, seg}, {25'd0, seg_tbl[nib]});
      check("one_low", $countones(~an), 1);
    end
  endtask

  task automatic deposit(input logic [31:0] v);
    dut.value_q = v;
    base   = v;
    base_k = k;
  endtask

  initial begin
    int unsigned cnt;
    bit found;
    logic [7:0] exp_an;

    seg_tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    // Reset held for three cycles, then the first released cycle.
    repeat (3) step();
    check("rst_hold_anode", {24'd0, an}, 32'hFF);
    rst_n = 1'b1;
    step();
    check("first_anode", {24'd0, an}, 32'hFE);
    check("first_seg", {25'd0, seg}, {25'd0, 7'b0000001});

    // Scan order, one sample per digit period.
    for (int i = 1; i <= 8; i++) begin
      repeat (REF) step();
      exp_an = ~(8'b1 << (i % 8));
      check("scan_order", {24'd0, an}, {24'd0, exp_an});
      check("scan_zero", {25'd0, seg}, {25'd0, 7'b0000001});
    end

    // First tick: digit 0 shows 1.
    while (k < TICK + 1) step();
    check("tick_anode", {24'd0, an}, 32'hFE);
    check("tick_d0", {25'd0, seg}, {25'd0, 7'b1001111});

    // 0x0F then 0x10.
    while (k < 15 * TICK + 1) step();
    check("hexF_d0", {25'd0, seg}, {25'd0, 7'b0111000});
    repeat (REF) step();
    check("hexF_d1", {25'd0, seg}, {25'd0, 7'b0000001});
    while (k < 16 * TICK + 1) step();
    check("hex10_d0", {25'd0, seg}, {25'd0, 7'b0000001});
    repeat (REF) step();
    check("hex10_d1", {25'd0, seg}, {25'd0, 7'b1001111});

    // Wrap from all-ones to zero, deposited right after a tick edge.
    while (k % TICK != 0) step();
    deposit(32'hFFFF_FFFF);
    cnt = 0;
    repeat (8 * REF) begin
      step();
      if (seg == 7'b0111000) cnt++;
    end
    check("wrap_pre_all_F", cnt, 8 * REF);
    while (k % TICK != 0) step();
    cnt = 0;
    repeat (8 * REF) begin
      step();
      if (seg == 7'b0000001) cnt++;
    end
    check("wrap_post_all_0", cnt, 8 * REF);

    // Reset while digit 5 is being driven.
    found = 1'b0;
    for (int i = 0; i < 8 * REF + 2 && !found; i++) begin
      step();
      if (an == 8'hDF) found = 1'b1;
    end
    check("wait_idx5", {31'd0, found}, 1);
    rst_n = 1'b0;
    step();
    check("midscan_rst_anode", {24'd0, an}, 32'hFF);
    check("midscan_rst_seg", {25'd0, seg}, 32'h7F);
    rst_n = 1'b1;
    step();
    check("restart_anode", {24'd0, an}, 32'hFE);
    check("restart_seg", {25'd0, seg}, {25'd0, 7'b0000001});

    // Random run lengths, resets and value deposits.
    for (int r = 0; r < 30; r++) begin
      repeat ($urandom_range(1, 150)) step();
      case ($urandom_range(0, 3))
        0: begin
          rst_n = 1'b0;
          repeat ($urandom_range(1, 3)) step();
          rst_n = 1'b1;
        end
        1: deposit($urandom);
        2: deposit({$urandom_range(0, 15), 28'hFFF_FFFF});
        default: ;
      endcase
    end
    repeat (2 * TICK) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
